// File: rtl/mips_interrupt_controller.sv
// Edge-triggered interrupt controller with PENDING/MASK/CAUSE registers feeding a single core interrupt line.
// Optional macro IRQ_SYNC_EN inserts a two-flop synchronizer on i_irq ahead of edge detection.
module mips_interrupt_controller #(
  parameter int NUM_IRQ = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [3:0]         i_addr,
  input  logic               i_we,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata,
  output logic               o_external_interrupt
);

  localparam logic [3:0] ADDR_PENDING = 4'h0;
  localparam logic [3:0] ADDR_MASK    = 4'h4;
  localparam logic [3:0] ADDR_CAUSE   = 4'h8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] arm_q, arm_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [3:0]         cause_id_q, cause_id_d;
  state_e             state_q, state_d;
  logic               ext_q;

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] cur_sel;
  logic               cur_live;
  logic               unused_wdata;

  assign unused_wdata = ^i_wdata[31:NUM_IRQ];

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_irq;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = i_irq;
`endif

  function automatic logic [3:0] lowest_index(input logic [NUM_IRQ-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (v[k]) idx = 4'(k);
    end
    return idx;
  endfunction

  // A line is armed only once it has been seen low since reset, so a line
  // already high when reset releases does not register as a fresh edge.
  assign arm_d = arm_q | ~i_irq;
  assign rise  = irq_s & ~prev_q & arm_q;
  assign clr   = (i_we && (i_addr == ADDR_PENDING)) ? i_wdata[NUM_IRQ-1:0] : '0;

  assign pending_d = (pending_q & ~clr) | rise;
  assign mask_d    = (i_we && (i_addr == ADDR_MASK)) ? i_wdata[NUM_IRQ-1:0] : mask_q;

  assign active   = pending_q & mask_q;
  assign cur_sel  = NUM_IRQ'(1) << cause_id_q;
  assign cur_live = |(active & cur_sel);

  always_comb begin
    state_d    = state_q;
    cause_id_d = cause_id_q;
    unique case (state_q)
      IDLE: begin
        if (|active) begin
          state_d    = ASSERT;
          cause_id_d = lowest_index(active);
        end
      end
      ASSERT: begin
        if (!cur_live) state_d = GAP;
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_q     <= '0;
      arm_q      <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      cause_id_q <= '0;
      state_q    <= IDLE;
      ext_q      <= 1'b0;
    end else begin
      prev_q     <= irq_s;
      arm_q      <= arm_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      cause_id_q <= cause_id_d;
      state_q    <= state_d;
      ext_q      <= (state_d == ASSERT);
    end
  end

  assign o_external_interrupt = ext_q;

  always_comb begin
    o_rdata = '0;
    unique case (i_addr)
      ADDR_PENDING: o_rdata = 32'(pending_q);
      ADDR_MASK:    o_rdata = 32'(mask_q);
      ADDR_CAUSE:   o_rdata = {ext_q, 27'd0, cause_id_q};
      default:      o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_interrupt_controller.sv
// Randomized bench for mips_interrupt_controller against a cycle-level reference model, plus directed scenarios.
module tb_mips_interrupt_controller;

  localparam int N = 8;
`ifdef IRQ_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [N-1:0]  i_irq = '0;
  logic [3:0]    i_addr = '0;
  logic          i_we = 1'b0;
  logic [31:0]   i_wdata = '0;
  logic [31:0]   o_rdata;
  logic          o_external_interrupt;

  mips_interrupt_controller #(.NUM_IRQ(N)) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .i_irq               (i_irq),
    .i_addr              (i_addr),
    .i_we                (i_we),
    .i_wdata             (i_wdata),
    .o_rdata             (o_rdata),
    .o_external_interrupt(o_external_interrupt)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: state 0 = idle, 1 = interrupt raised, 2 = forced low gap
  logic [N-1:0] m_pend, m_mask, m_prev, m_arm, m_s1, m_s2;
  int           m_state, m_id;

  function automatic int first_set(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [3:0] a);
    if (a == 4'h0) return 32'(m_pend);
    if (a == 4'h4) return 32'(m_mask);
    if (a == 4'h8) return ((m_state == 1) ? 32'h8000_0000 : 32'h0) | 32'(m_id);
    return 32'h0;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_mask = '0; m_prev = '0; m_arm = '0; m_s1 = '0; m_s2 = '0;
    m_state = 0; m_id = 0;
  endtask

  task automatic model_edge();
    logic [N-1:0] src, rise, clr, np, nm;
    int ns, nid, w;
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    src  = (SYNC_LAT != 0) ? m_s2 : i_irq;
    rise = src & ~m_prev & m_arm;
    clr  = (i_we && i_addr == 4'h0) ? i_wdata[N-1:0] : '0;
    np   = (m_pend & ~clr) | rise;
    nm   = (i_we && i_addr == 4'h4) ? i_wdata[N-1:0] : m_mask;
    ns   = m_state;
    nid  = m_id;
    if (m_state == 0) begin
      w = first_set(m_pend & m_mask);
      if (w >= 0) begin ns = 1; nid = w; end
    end else if (m_state == 1) begin
      if (!(m_pend[m_id] && m_mask[m_id])) ns = 2;
    end else begin
      ns = 0;
    end
    m_arm   = m_arm | ~i_irq;
    m_s2    = m_s1;
    m_s1    = i_irq;
    m_prev  = src;
    m_pend  = np;
    m_mask  = nm;
    m_state = ns;
    m_id    = nid;
  endtask

  task automatic cycle();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    chk("oext", 32'(o_external_interrupt), 32'(m_state == 1));
    chk("rdata", o_rdata, m_rdata(i_addr));
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    cycle();
    i_we = 1'b0; i_wdata = '0;
  endtask

  task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string tag);
    i_addr = a;
    #1;
    chk(tag, o_rdata, exp);
  endtask

  initial begin
    int rises, first_i, acked;
    logic prev_o;
    model_reset();

    // reset state
    repeat (2) cycle();
    i_rst_n = 1'b1;
    peek(4'h0, 32'h0, "rst_pend");
    peek(4'h4, 32'h0, "rst_mask");
    peek(4'h8, 32'h0, "rst_cause");
    chk("rst_oext", 32'(o_external_interrupt), 32'h0);
    cycle();

    // single source, masked in
    wr(4'h4, 32'h01);
    i_irq = 8'h01;
    cycle();
    repeat (SYNC_LAT) cycle();
    peek(4'h0, 32'h01, "s1_pend");
    chk("s1_low", 32'(o_external_interrupt), 32'h0);
    i_irq = 8'h00;
    cycle();
    chk("s1_oext", 32'(o_external_interrupt), 32'h1);
    peek(4'h8, 32'h8000_0000, "s1_cause");
    wr(4'h0, 32'h01);
    repeat (3) cycle();
    chk("s1_done", 32'(o_external_interrupt), 32'h0);

    // simultaneous sources: lowest index first, no preemption, gap between
    wr(4'h4, 32'hFF);
    i_irq = 8'h24;
    cycle();
    repeat (SYNC_LAT) cycle();
    i_irq = 8'h00;
    cycle();
    peek(4'h8, 32'h8000_0002, "s2_cause2");
    wr(4'h0, 32'h04);
    chk("s2_hold", 32'(o_external_interrupt), 32'h1);
    cycle();
    chk("s2_gap", 32'(o_external_interrupt), 32'h0);
    cycle();
    cycle();
    chk("s2_reassert", 32'(o_external_interrupt), 32'h1);
    peek(4'h8, 32'h8000_0005, "s2_cause5");
    wr(4'h0, 32'h20);
    repeat (3) cycle();

    // masked-out request stays pending until enabled
    wr(4'h4, 32'h00);
    i_irq = 8'h08;
    cycle();
    repeat (SYNC_LAT) cycle();
    i_irq = 8'h00;
    cycle();
    peek(4'h0, 32'h08, "s3_pend");
    chk("s3_masked", 32'(o_external_interrupt), 32'h0);
    wr(4'h4, 32'h08);
    chk("s3_still_low", 32'(o_external_interrupt), 32'h0);
    cycle();
    chk("s3_assert", 32'(o_external_interrupt), 32'h1);
    wr(4'h0, 32'h08);
    repeat (3) cycle();

    // set beats clear in the same cycle
    wr(4'h4, 32'h00);
    i_irq = 8'h01;
    repeat (SYNC_LAT) cycle();
    wr(4'h0, 32'h01);
    peek(4'h0, 32'h01, "s4_set_wins");
    i_irq = 8'h00;
    wr(4'h0, 32'h01);
    cycle();
    peek(4'h0, 32'h00, "s4_cleared");

    // held line: one assertion only, latency check
    wr(4'h4, 32'h02);
    i_irq = 8'h02;
    rises = 0; first_i = -1; acked = 0; prev_o = o_external_interrupt;
    for (int i = 0; i < 20; i++) begin
      if (o_external_interrupt && acked == 0) begin
        i_we = 1'b1; i_addr = 4'h0; i_wdata = 32'h02; acked = 1;
      end
      cycle();
      i_we = 1'b0; i_wdata = '0;
      if (o_external_interrupt && !prev_o) rises++;
      if (o_external_interrupt && first_i < 0) first_i = i;
      prev_o = o_external_interrupt;
    end
    i_irq = 8'h00;
    repeat (5) begin
      cycle();
      if (o_external_interrupt && !prev_o) rises++;
      prev_o = o_external_interrupt;
    end
    chk("s5_rises", 32'(rises), 32'd1);
    chk("s5_latency", 32'(first_i), 32'(1 + SYNC_LAT));

    // asynchronous reset mid-assert, then a line high across release
    wr(4'h4, 32'h01);
    i_irq = 8'h01;
    cycle();
    repeat (SYNC_LAT) cycle();
    i_irq = 8'h00;
    cycle();
    chk("s6_assert", 32'(o_external_interrupt), 32'h1);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("s6_async_drop", 32'(o_external_interrupt), 32'h0);
    model_reset();
    i_irq = 8'h01;
    cycle();
    i_rst_n = 1'b1;
    peek(4'h0, 32'h0, "s6_pend0");
    peek(4'h4, 32'h0, "s6_mask0");
    peek(4'h8, 32'h0, "s6_cause0");
    wr(4'h4, 32'h01);
    repeat (6) cycle();
    peek(4'h0, 32'h0, "s6_no_edge");
    chk("s6_no_assert", 32'(o_external_interrupt), 32'h0);
    i_irq = 8'h00;
    cycle();
    i_irq = 8'h01;
    cycle();
    repeat (SYNC_LAT) cycle();
    i_irq = 8'h00;
    cycle();
    chk("s6_new_edge", 32'(o_external_interrupt), 32'h1);
    wr(4'h0, 32'h01);
    repeat (3) cycle();

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 2) == 0) i_irq = i_irq ^ N'(1 << $urandom_range(0, N - 1));
      i_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 4))
        0:       i_addr = 4'h0;
        1:       i_addr = 4'h4;
        2:       i_addr = 4'h8;
        3:       i_addr = 4'hC;
        default: i_addr = 4'h6;
      endcase
      i_wdata = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        i_rst_n = 1'b0;
        #1;
        model_reset();
        chk("rnd_rst_drop", 32'(o_external_interrupt), 32'h0);
        cycle();
        i_rst_n = 1'b1;
      end else begin
        cycle();
      end
    end
    i_we = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
